vga_sync_generator: RTL

Consumes the single-cycle pixel strobe produced by the pixel clock generator and turns it into VGA raster timing: horizontal/vertical pixel counters, hsync/vsync, a video-active flag, and line/frame start pulses. Everything runs in the `systemClk` domain, and the pixel strobe acts only as a clock enable. Downstream pixel renderers and the Game-of-Life frame logic sit after this block, and it feeds the VGA pins directly.

---
 rtl/vga_sync_generator.sv | 136 +++++++++++++
 1 files changed

// File: rtl/vga_sync_generator.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_generator
// Description : VGA raster timing (counters, syncs, video-active, line/frame
//               start pulses) advanced by a single-cycle pixel strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_generator #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0,
  parameter int   COORD_W  = 10
) (
  input  logic               systemClk,
  input  logic               rst,
  input  logic               pixelClk,
  output logic [COORD_W-1:0] hpos,
  output logic [COORD_W-1:0] vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               videoActive,
  output logic               lineStart,
  output logic               frameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] C_ONE     = COORD_W'(1);
  localparam logic [COORD_W-1:0] C_H_FRONT = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] C_H_SYNC  = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] C_H_BACK  = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] C_H_LAST  = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] C_V_FRONT = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] C_V_SYNC  = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] C_V_BACK  = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [COORD_W-1:0] C_V_LAST  = COORD_W'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    ST_VIS   = 2'd0,
    ST_FRONT = 2'd1,
    ST_SYNC  = 2'd2,
    ST_BACK  = 2'd3
  } region_e;

  region_e            hstate_q, hstate_d;
  region_e            vstate_q, vstate_d;
  logic [COORD_W-1:0] hpos_q, hpos_d;
  logic [COORD_W-1:0] vpos_q, vpos_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               video_q, video_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic               h_wrap;
  logic               v_wrap;

  always_comb begin
    hpos_d        = hpos_q;
    vpos_d        = vpos_q;
    hstate_d      = hstate_q;
    vstate_d      = vstate_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    h_wrap        = (hpos_q == C_H_LAST);
    v_wrap        = (vpos_q == C_V_LAST);

    if (pixelClk) begin
      hpos_d = h_wrap ? '0 : hpos_q + C_ONE;
      case (hstate_q)
        ST_VIS:   if (hpos_d == C_H_FRONT) hstate_d = ST_FRONT;
        ST_FRONT: if (hpos_d == C_H_SYNC)  hstate_d = ST_SYNC;
        ST_SYNC:  if (hpos_d == C_H_BACK)  hstate_d = ST_BACK;
        default:  if (h_wrap)              hstate_d = ST_VIS;
      endcase

      // The vertical side moves only on the line wrap, keeping vsync line-aligned.
      if (h_wrap) begin
        vpos_d = v_wrap ? '0 : vpos_q + C_ONE;
        case (vstate_q)
          ST_VIS:   if (vpos_d == C_V_FRONT) vstate_d = ST_FRONT;
          ST_FRONT: if (vpos_d == C_V_SYNC)  vstate_d = ST_SYNC;
          ST_SYNC:  if (vpos_d == C_V_BACK)  vstate_d = ST_BACK;
          default:  if (v_wrap)              vstate_d = ST_VIS;
        endcase
      end

      line_start_d  = h_wrap;
      frame_start_d = h_wrap && v_wrap;
    end

    hsync_d = (hstate_d == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
    vsync_d = (vstate_d == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
    video_d = (hstate_d == ST_VIS) && (vstate_d == ST_VIS);
  end

  always_ff @(posedge systemClk) begin
    if (rst) begin
      hpos_q        <= '0;
      vpos_q        <= '0;
      hstate_q      <= ST_VIS;
      vstate_q      <= ST_VIS;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_q       <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      hstate_q      <= hstate_d;
      vstate_q      <= vstate_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_q       <= video_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign videoActive = video_q;
  assign lineStart   = line_start_q;
  assign frameStart  = frame_start_q;

endmodule
`default_nettype wire
